// File: rtl/bcd_ascii_serializer.sv
// bcd_ascii_serializer: latches a 3-digit packed BCD value on start and streams
// its ASCII digits one byte per valid/ready transfer.
// Optional feature: define BCD_ASCII_CRLF_EN to append CR, LF after the ones digit.
module bcd_ascii_serializer #(
  parameter int unsigned LZ_SUPPRESS = 1,
  parameter logic [7:0]  BAD_CHAR    = 8'h3F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] pbcd,
  output logic       busy,
  output logic       done,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int unsigned BCD_W  = 10;
  localparam int unsigned CHAR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_H,
    S_SEND_T,
    S_SEND_O,
`ifdef BCD_ASCII_CRLF_EN
    S_SEND_CR,
    S_SEND_LF,
`endif
    S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [BCD_W-1:0]    dig_q, dig_d;
  logic [CHAR_W-1:0]   out_char_q, out_char_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                xfer;

  // Map one BCD nibble to its ASCII digit, or BAD_CHAR if out of range.
  function automatic logic [CHAR_W-1:0] to_ascii(input logic [3:0] nib);
    if (nib > 4'd9) return BAD_CHAR;
    return CHAR_W'(8'h30 + {4'h0, nib});
  endfunction

  // Character offered while sitting in a given digit state.
  function automatic logic [CHAR_W-1:0] digit_char(input state_e s, input logic [BCD_W-1:0] d);
    case (s)
      S_SEND_H: return to_ascii({2'b00, d[9:8]});
      S_SEND_T: return to_ascii(d[7:4]);
      S_SEND_O: return to_ascii(d[3:0]);
      default:  return 8'h00;
    endcase
  endfunction

  // First digit state; suppression stops at the first nonzero nibble, ones always sent.
  function automatic state_e first_state(input logic [BCD_W-1:0] d);
    if (LZ_SUPPRESS != 0 && d[9:8] == 2'b00) begin
      if (d[7:4] == 4'd0) return S_SEND_O;
      return S_SEND_T;
    end
    return S_SEND_H;
  endfunction

  assign xfer = out_valid_q & out_ready;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    dig_d       = dig_q;
    out_char_d  = out_char_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE, S_FINISH: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        if (start) begin
          dig_d       = pbcd;
          state_d     = first_state(pbcd);
          busy_d      = 1'b1;
          out_valid_d = 1'b1;
          out_char_d  = digit_char(first_state(pbcd), pbcd);
        end
      end
      S_SEND_H: begin
        if (xfer) begin
          state_d    = S_SEND_T;
          out_char_d = digit_char(S_SEND_T, dig_q);
        end
      end
      S_SEND_T: begin
        if (xfer) begin
          state_d    = S_SEND_O;
          out_char_d = digit_char(S_SEND_O, dig_q);
        end
      end
      S_SEND_O: begin
        if (xfer) begin
`ifdef BCD_ASCII_CRLF_EN
          state_d    = S_SEND_CR;
          out_char_d = 8'h0D;
`else
          state_d     = S_FINISH;
          busy_d      = 1'b0;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
`endif
        end
      end
`ifdef BCD_ASCII_CRLF_EN
      S_SEND_CR: begin
        if (xfer) begin
          state_d    = S_SEND_LF;
          out_char_d = 8'h0A;
        end
      end
      S_SEND_LF: begin
        if (xfer) begin
          state_d     = S_FINISH;
          busy_d      = 1'b0;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
        end
      end
`endif
      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dig_q       <= '0;
      out_char_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dig_q       <= dig_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_char  = out_char_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// Bench for bcd_ascii_serializer: two instances (LZ_SUPPRESS=1 and 0) share
// stimulus; a string-level model predicts every output each cycle.
module tb_bcd_ascii_serializer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [9:0] pbcd;
  logic       out_ready;
  logic       busy      [2];
  logic       done      [2];
  logic [7:0] out_char  [2];
  logic       out_valid [2];

  int checks;
  int errors;

  // Model: expected string per instance, next position, last sent char, done due.
  logic [7:0] s    [2][5];
  int         len  [2];
  int         pos  [2];
  logic [7:0] last [2];
  bit         expd [2];

  bcd_ascii_serializer #(.LZ_SUPPRESS(1)) u_lz (
    .clk(clk), .reset(reset), .start(start), .pbcd(pbcd),
    .busy(busy[0]), .done(done[0]), .out_char(out_char[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready)
  );

  bcd_ascii_serializer #(.LZ_SUPPRESS(0)) u_nolz (
    .clk(clk), .reset(reset), .start(start), .pbcd(pbcd),
    .busy(busy[1]), .done(done[1]), .out_char(out_char[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Build the expected character string for value v on instance i (0 = suppressing).
  function automatic void load(int i, logic [9:0] v);
    logic [3:0] n [3];
    int first;
    n[0] = {2'b00, v[9:8]};
    n[1] = v[7:4];
    n[2] = v[3:0];
    first = 0;
    if (i == 0)
      while (first < 2 && n[first] == 4'd0) first++;
    len[i] = 0;
    pos[i] = 0;
    for (int k = first; k < 3; k++) begin
      s[i][len[i]] = (n[k] > 4'd9) ? 8'h3F : 8'(8'h30 + {4'h0, n[k]});
      len[i]++;
    end
`ifdef BCD_ASCII_CRLF_EN
    s[i][len[i]] = 8'h0D; len[i]++;
    s[i][len[i]] = 8'h0A; len[i]++;
`endif
  endfunction

  // One cycle: check outputs against the model, then drive inputs and advance the model.
  task automatic step(input bit st, input logic [9:0] v, input bit rdy, input bit rst);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int r;
      r = len[i] - pos[i];
      check($sformatf("busy%0d", i), 32'(busy[i]), 32'(r > 0));
      check($sformatf("valid%0d", i), 32'(out_valid[i]), 32'(r > 0));
      check($sformatf("done%0d", i), 32'(done[i]), 32'(expd[i]));
      check($sformatf("char%0d", i), 32'(out_char[i]), 32'((r > 0) ? s[i][pos[i]] : last[i]));
    end
    start     = st;
    pbcd      = v;
    out_ready = rdy;
    reset     = rst;
    for (int i = 0; i < 2; i++) begin
      int r;
      r = len[i] - pos[i];
      expd[i] = 1'b0;
      if (rst) begin
        len[i] = 0; pos[i] = 0; last[i] = 8'h00;
      end else if (r > 0 && rdy) begin
        last[i] = s[i][pos[i]];
        pos[i]++;
        expd[i] = (pos[i] == len[i]);
      end else if (r == 0 && st) begin
        load(i, v);
      end
    end
  endtask

  task automatic kick(input logic [9:0] v);
    step(1'b1, v, 1'b1, 1'b0);
  endtask

  // Run until both strings complete; optional noise on start/pbcd while both busy.
  task automatic drain(input int pct, input bit noise);
    int guard;
    bit rdy;
    bit st;
    logic [9:0] v;
    guard = 0;
    while ((len[0] - pos[0]) > 0 || (len[1] - pos[1]) > 0 || expd[0] || expd[1]) begin
      rdy = ($urandom_range(99) < pct);
      st  = 1'b0;
      v   = pbcd;
      if (noise && (len[0] - pos[0]) > 0 && (len[1] - pos[1]) > 0) begin
        st = 1'($urandom_range(1));
        v  = 10'($urandom);
      end
      step(st, v, rdy, 1'b0);
      guard++;
      if (guard > 300) begin
        check("drain_timeout", 32'd1, 32'd0);
        break;
      end
    end
    step(1'b0, pbcd, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 2; i++) begin
      len[i] = 0; pos[i] = 0; last[i] = 8'h00; expd[i] = 1'b0;
    end
    reset = 1'b1; start = 1'b0; pbcd = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b0, 10'h000, 1'b0, 1'b1);
    step(1'b0, 10'h000, 1'b0, 1'b1);
    step(1'b0, 10'h000, 1'b1, 1'b0);
    step(1'b0, 10'h000, 1'b1, 1'b0);

    kick(10'h255); drain(100, 1'b0);
    kick(10'h007); drain(100, 1'b0);
    kick(10'h000); drain(100, 1'b0);

    // Stall while the second character is offered.
    step(1'b1, 10'h142, 1'b0, 1'b0);
    step(1'b0, 10'h142, 1'b1, 1'b0);
    step(1'b0, 10'h142, 1'b0, 1'b0);
    step(1'b0, 10'h142, 1'b0, 1'b0);
    step(1'b0, 10'h142, 1'b0, 1'b0);
    drain(100, 1'b0);

    // Ignored restart and pbcd churn mid-string.
    kick(10'h105);
    step(1'b1, 10'h299, 1'b1, 1'b0);
    drain(70, 1'b1);

    // Reset while the second character is offered.
    kick(10'h231);
    step(1'b0, 10'h231, 1'b1, 1'b0);
    step(1'b0, 10'h231, 1'b1, 1'b1);
    step(1'b0, 10'h231, 1'b1, 1'b0);
    step(1'b0, 10'h231, 1'b1, 1'b0);
    kick(10'h099); drain(100, 1'b0);

    kick(10'h1A3); drain(100, 1'b0);

    // Back-to-back start landing in the finish cycle.
    kick(10'h011);
    step(1'b0, 10'h011, 1'b1, 1'b0);
    step(1'b0, 10'h011, 1'b1, 1'b0);
    step(1'b0, 10'h011, 1'b1, 1'b0);
    step(1'b1, 10'h308, 1'b1, 1'b0);
    drain(100, 1'b0);

    for (int n = 0; n < 40; n++) begin
      kick(10'($urandom));
      drain(int'($urandom_range(100, 20)), 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_ascii_serializer.md
Name: bcd_ascii_serializer

Overview:
Downstream consumer of the binary-to-packed-BCD converter stage. Latches a 10-bit packed BCD value (3 decimal digits) on a start strobe and emits its ASCII digit characters one byte at a time over a valid/ready stream toward the terminal/UART transmit path. Optional leading-zero suppression; flags invalid BCD nibbles.

Parameters:
LZ_SUPPRESS, 1, 1 = skip leading zero digits (ones digit always sent); 0 = always send 3 digits
BAD_CHAR, 8'h3F, ASCII code emitted for any digit nibble > 9 ('?')

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to serialize pbcd; sampled only when busy=0
pbcd  input  10  packed BCD: [9:8] hundreds (0-3), [7:4] tens, [3:0] ones
busy  output  1  high from cycle after accepted start until string complete
done  output  1  one-cycle pulse after final character transferred
out_char  output  8  ASCII character being offered
out_valid  output  1  out_char is valid
out_ready  input  1  downstream accepts out_char this cycle

Behaviour:
- Reset (sync, active-high, priority over all inputs): state IDLE, busy=0, done=0, out_valid=0, out_char=8'h00, latched digits cleared. Reset mid-string abandons it; nothing further emitted.
- Transfer occurs on any rising edge where out_valid=1 and out_ready=1.
- FSM states: IDLE, SEND_H, SEND_T, SEND_O, (SEND_CR, SEND_LF if feature enabled), FINISH.
- IDLE: start=1 -> latch pbcd into internal register; next cycle busy=1, out_valid=1, out_char = first emitted digit. Latency start->first valid char = 1 cycle.
- First digit selection (LZ_SUPPRESS=1): hundreds≠0 -> SEND_H; else tens≠0 -> SEND_T; else SEND_O. LZ_SUPPRESS=0 -> always SEND_H. Once a digit is sent, all lower digits are sent (e.g. 105 -> "105").
- Hundreds 2-bit field zero-extended to 4 bits before conversion.
- Digit to ASCII: nibble 0-9 -> 8'h30 + nibble; nibble 10-15 -> BAD_CHAR. A nonzero invalid nibble counts as nonzero for suppression.
- In each SEND_x: out_char and out_valid held stable until transfer; on transfer advance to next state and present next char the following cycle (back-to-back, 1 char/cycle max with out_ready held high). out_valid never deasserts before transfer.
- After last char transfer -> FINISH for one cycle: out_valid=0, busy=0, done=1; then IDLE. start asserted during FINISH is accepted (same as IDLE).
- start while busy=1 ignored; pbcd changes after acceptance do not affect the current string.
- out_char retains last value when out_valid=0 (don't-care to consumer).

Optional Feature:
Macro BCD_ASCII_CRLF_EN. Defined: after ones digit, emit 8'h0D then 8'h0A with identical handshake rules, then FINISH; done follows LF transfer. Undefined: string ends after ones digit; SEND_CR/SEND_LF states not present.

Test Plan:
- pbcd=10'h255, start 1 cycle at N, out_ready=1 -> out_char 0x32,0x35,0x35 at edges N+1..N+3, done=1 at N+4, busy low at N+4.
- pbcd=10'h007, LZ_SUPPRESS=1 -> single char 0x37, done next cycle; LZ_SUPPRESS=0 -> 0x30,0x30,0x37; pbcd=10'h000 with LZ=1 -> single 0x30.
- pbcd=10'h142, out_ready low 3 cycles while 0x34 offered -> out_char stays 0x34, out_valid stays 1; full string "142" delivered with no loss or duplication.
- Start pbcd=10'h105, then pulse start with pbcd=10'h299 and change pbcd mid-string -> output "105" only; second start ignored; done pulses once.
- Reset asserted while second char of 10'h231 offered -> next edge out_valid=0, busy=0, done=0; later start pbcd=10'h099 (LZ=1) -> "99".
- pbcd=10'h1A3 -> "1?3" (0x31,0x3F,0x33); with BCD_ASCII_CRLF_EN defined, 0x0D,0x0A follow before done.
